// File: rtl/dmem_responder_if.sv
// Load/store request and response channel between the core and dmem_responder.
interface dmem_responder_if #(
   parameter int XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;
   logic [1:0]      req_size;
   logic            req_lunsigned;
   logic [XLEN-1:0] req_pc;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_rdata;
   logic            rsp_err;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_size, req_lunsigned, req_pc,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_err,
      input  rsp_ready
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_size, req_lunsigned, req_pc,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_err,
      output rsp_ready
   );
endinterface

// File: rtl/dmem_responder.sv
// Serialized data-memory responder: latency model, store lane merge, load extension.
// Define DMEM_STORE_TRACE_EN to print a line for every committed store in simulation.
module dmem_responder #(
   parameter int XLEN        = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input logic             clk,
   input logic             reset,
   dmem_responder_if.slave bus
);
   // state | meaning
   // IDLE  | ready for a request
   // BUSY  | counting down the access latency
   // RESP  | response presented, held until rsp_ready
   typedef enum logic [1:0] {IDLE, BUSY, RESP} dmemState;

   localparam int  IDXW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int  CW      = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam int  LOADCNT = (LATENCY > 1) ? LATENCY - 2 : 0;
   localparam bit  DIRECT  = (LATENCY == 1);

   dmemState        state, stateNext;
   logic [CW-1:0]   cnt;
   logic            liveQ;
   logic            weQ, lunsQ;
   logic [1:0]      sizeQ;
   logic [XLEN-1:0] addrQ, wdataQ;
   logic [XLEN-1:0] rdataQ;
   logic            errQ;

   logic [XLEN-1:0] mem [DEPTH_WORDS];

   logic            accept, commit;
   logic            cWe, cLuns;
   logic [1:0]      cSize;
   logic [XLEN-1:0] cAddr, cWdata;
   logic [XLEN-1:0] wordIdx, oldWord, mergedWord, loadData;
   logic [7:0]      byteSel;
   logic [15:0]     halfSel;
   logic            isWord, isHalf, accErr;

   assign bus.req_ready = liveQ && (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_rdata = rdataQ;
   assign bus.rsp_err   = errQ;
   assign accept        = bus.req_valid && bus.req_ready;

   // With single-cycle latency the accept edge is also the commit edge, so use the live inputs.
   assign cWe    = DIRECT ? bus.req_we        : weQ;
   assign cLuns  = DIRECT ? bus.req_lunsigned : lunsQ;
   assign cSize  = DIRECT ? bus.req_size      : sizeQ;
   assign cAddr  = DIRECT ? bus.req_addr      : addrQ;
   assign cWdata = DIRECT ? bus.req_wdata     : wdataQ;
   assign commit = DIRECT ? accept : ((state == BUSY) && (cnt == '0));

   always_comb begin
      wordIdx    = cAddr >> 2;
      isWord     = (cSize == 2'b00) || (cSize == 2'b11);
      isHalf     = (cSize == 2'b01);
      accErr     = (isHalf && cAddr[0]) || (isWord && (cAddr[1:0] != 2'b00)) ||
                   (wordIdx >= XLEN'(DEPTH_WORDS));
      oldWord    = mem[wordIdx[IDXW-1:0]];
      byteSel    = oldWord[{cAddr[1:0], 3'b000} +: 8];
      halfSel    = oldWord[{cAddr[1], 4'b0000} +: 16];
      mergedWord = oldWord;
      if (isWord)
         mergedWord = cWdata;
      else if (isHalf)
         mergedWord[{cAddr[1], 4'b0000} +: 16] = cWdata[15:0];
      else
         mergedWord[{cAddr[1:0], 3'b000} +: 8] = cWdata[7:0];
      if (isWord)
         loadData = oldWord;
      else if (isHalf)
         loadData = cLuns ? {{(XLEN-16){1'b0}}, halfSel} : {{(XLEN-16){halfSel[15]}}, halfSel};
      else
         loadData = cLuns ? {{(XLEN-8){1'b0}}, byteSel} : {{(XLEN-8){byteSel[7]}}, byteSel};
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (accept) stateNext = DIRECT ? RESP : BUSY;
         BUSY:    if (cnt == '0) stateNext = RESP;
         RESP:    if (bus.rsp_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         liveQ  <= 1'b0;
         weQ    <= 1'b0;
         lunsQ  <= 1'b0;
         sizeQ  <= 2'b00;
         addrQ  <= '0;
         wdataQ <= '0;
         rdataQ <= '0;
         errQ   <= 1'b0;
      end else begin
         liveQ <= 1'b1;
         state <= stateNext;
         if (accept) begin
            weQ    <= bus.req_we;
            lunsQ  <= bus.req_lunsigned;
            sizeQ  <= bus.req_size;
            addrQ  <= bus.req_addr;
            wdataQ <= bus.req_wdata;
            cnt    <= CW'(LOADCNT);
         end else if ((state == BUSY) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end
         if (commit) begin
            rdataQ <= (accErr || cWe) ? '0 : loadData;
            errQ   <= accErr;
         end else if ((state == RESP) && bus.rsp_ready) begin
            rdataQ <= '0;
            errQ   <= 1'b0;
         end
      end
   end

`ifdef DMEM_STORE_TRACE_EN
   logic [XLEN-1:0] pcQ;
   logic [XLEN-1:0] cPc;

   assign cPc = DIRECT ? bus.req_pc : pcQ;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         pcQ <= '0;
      else if (accept)
         pcQ <= bus.req_pc;
   end
`endif

   // Array has no reset: contents survive reset, and commit is already gated by the reset state.
   always_ff @(posedge clk) begin
      if (commit && cWe && !accErr) begin
         mem[wordIdx[IDXW-1:0]] <= mergedWord;
`ifdef DMEM_STORE_TRACE_EN
         $display("pc = %h: dataaddr = %h, memdata = %h", cPc, cAddr, mergedWord);
`endif
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table plus backpressure and reset sequences.
module tb_dmem_responder;
   localparam int XLEN  = 32;
   localparam int DEPTH = 1024;
   localparam int LAT   = 2;
   localparam int NV    = 31;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        luns;
      logic [31:0] expRdata;
      logic        expErr;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;
   vec_t vecs [NV];
   exp_t sbq [$];

   always #5 clk = ~clk;

   dmem_responder_if #(.XLEN(XLEN)) bus ();

   dmem_responder #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic popCheck(input string name);
      exp_t e;
      if (sbq.size() == 0) begin
         check({name, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sbq.pop_front();
         check({name, "_rdata"}, bus.rsp_rdata, e.rdata);
         check({name, "_err"}, {31'd0, bus.rsp_err}, {31'd0, e.err});
      end
   endtask

   task automatic drive(input vec_t v, input int idx);
      bus.req_valid     = 1'b1;
      bus.req_we        = v.we;
      bus.req_addr      = v.addr;
      bus.req_wdata     = v.wdata;
      bus.req_size      = v.size;
      bus.req_lunsigned = v.luns;
      bus.req_pc        = 32'h0000_1000 + 32'(idx * 4);
   endtask

   task automatic doTxn(input vec_t v, input int idx);
      int n;
      @(negedge clk);
      drive(v, idx);
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("accept_wait[%0d]", idx), 32'(n < 20), 32'd1);
      @(posedge clk);
      sbq.push_back('{rdata: v.expRdata, err: v.expErr});
      #1;
      // scramble the request lines: they must be ignored after the accept edge
      bus.req_valid = 1'b0;
      bus.req_we    = ~v.we;
      bus.req_addr  = ~v.addr;
      bus.req_wdata = ~v.wdata;
      bus.req_size  = ~v.size;
      n = 1;
      while (bus.rsp_valid !== 1'b1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check($sformatf("latency[%0d]", idx), 32'(n), 32'(LAT));
      popCheck($sformatf("rsp[%0d]", idx));
      @(posedge clk);
      #1;
      check($sformatf("rsp_drop[%0d]", idx), {31'd0, bus.rsp_valid}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t v;
      logic [31:0] held;
      //            we    addr          wdata         sz    lu    rdata         err
      vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 2'd0, 1'b0, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 32'h10,       32'h0,        2'd0, 1'b0, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h13,       32'h00000080, 2'd2, 1'b0, 32'h0,        1'b0};
      vecs[3]  = '{1'b0, 32'h10,       32'h0,        2'd0, 1'b0, 32'h80ADBEEF, 1'b0};
      vecs[4]  = '{1'b0, 32'h13,       32'h0,        2'd2, 1'b0, 32'hFFFFFF80, 1'b0};
      vecs[5]  = '{1'b0, 32'h13,       32'h0,        2'd2, 1'b1, 32'h00000080, 1'b0};
      vecs[6]  = '{1'b1, 32'h20,       32'h00008001, 2'd1, 1'b0, 32'h0,        1'b0};
      vecs[7]  = '{1'b0, 32'h20,       32'h0,        2'd1, 1'b0, 32'hFFFF8001, 1'b0};
      vecs[8]  = '{1'b0, 32'h20,       32'h0,        2'd1, 1'b1, 32'h00008001, 1'b0};
      vecs[9]  = '{1'b0, 32'h21,       32'h0,        2'd1, 1'b0, 32'h0,        1'b1};
      vecs[10] = '{1'b1, 32'h12,       32'h11111111, 2'd0, 1'b0, 32'h0,        1'b1};
      vecs[11] = '{1'b0, 32'h1000,     32'h0,        2'd0, 1'b0, 32'h0,        1'b1};
      vecs[12] = '{1'b0, 32'h10,       32'h0,        2'd0, 1'b0, 32'h80ADBEEF, 1'b0};
      vecs[13] = '{1'b1, 32'h11,       32'hABCDEF7F, 2'd2, 1'b0, 32'h0,        1'b0};
      vecs[14] = '{1'b0, 32'h11,       32'h0,        2'd2, 1'b0, 32'h0000007F, 1'b0};
      vecs[15] = '{1'b0, 32'h10,       32'h0,        2'd0, 1'b0, 32'h80AD7FEF, 1'b0};
      vecs[16] = '{1'b0, 32'h12,       32'h0,        2'd2, 1'b1, 32'h000000AD, 1'b0};
      vecs[17] = '{1'b0, 32'h12,       32'h0,        2'd2, 1'b0, 32'hFFFFFFAD, 1'b0};
      vecs[18] = '{1'b1, 32'h22,       32'h1234F00D, 2'd1, 1'b0, 32'h0,        1'b0};
      vecs[19] = '{1'b0, 32'h20,       32'h0,        2'd0, 1'b0, 32'hF00D8001, 1'b0};
      vecs[20] = '{1'b0, 32'h22,       32'h0,        2'd1, 1'b1, 32'h0000F00D, 1'b0};
      vecs[21] = '{1'b0, 32'h22,       32'h0,        2'd1, 1'b0, 32'hFFFFF00D, 1'b0};
      vecs[22] = '{1'b1, 32'h24,       32'hCAFEBABE, 2'd3, 1'b0, 32'h0,        1'b0};
      vecs[23] = '{1'b0, 32'h24,       32'h0,        2'd3, 1'b1, 32'hCAFEBABE, 1'b0};
      vecs[24] = '{1'b1, 32'hFFC,      32'h5A5A5A5A, 2'd0, 1'b0, 32'h0,        1'b0};
      vecs[25] = '{1'b1, 32'hFFF,      32'h000000C3, 2'd2, 1'b0, 32'h0,        1'b0};
      vecs[26] = '{1'b0, 32'hFFC,      32'h0,        2'd0, 1'b0, 32'hC35A5A5A, 1'b0};
      vecs[27] = '{1'b1, 32'h1000,     32'h00000001, 2'd2, 1'b0, 32'h0,        1'b1};
      vecs[28] = '{1'b0, 32'h22,       32'h0,        2'd0, 1'b0, 32'h0,        1'b1};
      vecs[29] = '{1'b0, 32'hFFF,      32'h0,        2'd1, 1'b0, 32'h0,        1'b1};
      vecs[30] = '{1'b0, 32'h80000010, 32'h0,        2'd0, 1'b0, 32'h0,        1'b1};

      bus.req_valid     = 1'b0;
      bus.req_we        = 1'b0;
      bus.req_addr      = '0;
      bus.req_wdata     = '0;
      bus.req_size      = 2'd0;
      bus.req_lunsigned = 1'b0;
      bus.req_pc        = '0;
      bus.rsp_ready     = 1'b1;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
      check("rst_rdata", bus.rsp_rdata, 32'd0);
      check("rst_err", {31'd0, bus.rsp_err}, 32'd0);
      reset = 1'b1;
      #1;
      check("rel_req_ready_pre_edge", {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("rel_req_ready_post_edge", {31'd0, bus.req_ready}, 32'd1);

      for (int i = 0; i < NV; i++) doTxn(vecs[i], i);

      // response backpressure: held outputs, no accept while in RESP
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      v = '{1'b0, 32'h10, 32'h0, 2'd0, 1'b0, 32'h80AD7FEF, 1'b0};
      drive(v, 100);
      @(posedge clk);
      sbq.push_back('{rdata: v.expRdata, err: v.expErr});
      #1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("bp_valid_rise", {31'd0, bus.rsp_valid}, 32'd1);
      held = bus.rsp_rdata;
      popCheck("bp_load");
      v = '{1'b1, 32'h30, 32'h0BADF00D, 2'd0, 1'b0, 32'h0, 1'b0};
      drive(v, 101);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp_valid_hold[%0d]", k), {31'd0, bus.rsp_valid}, 32'd1);
         check($sformatf("bp_rdata_hold[%0d]", k), bus.rsp_rdata, held);
         check($sformatf("bp_req_ready[%0d]", k), {31'd0, bus.req_ready}, 32'd0);
      end
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_hs_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("bp_hs_rdata", bus.rsp_rdata, 32'd0);
      check("bp_hs_ready", {31'd0, bus.req_ready}, 32'd1);
      sbq.push_back('{rdata: 32'h0, err: 1'b0});
      @(posedge clk);
      #1;
      check("bp_late_accept", {31'd0, bus.req_ready}, 32'd0);
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("bp_store_valid", {31'd0, bus.rsp_valid}, 32'd1);
      popCheck("bp_store");
      @(posedge clk);
      #1;

      // reset in BUSY drops the pending store
      @(negedge clk);
      v = '{1'b1, 32'h30, 32'h12345678, 2'd0, 1'b0, 32'h0, 1'b0};
      drive(v, 102);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      check("mr_busy", {31'd0, bus.req_ready}, 32'd0);
      reset = 1'b0;
      #1;
      check("mr_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("mr_req_ready", {31'd0, bus.req_ready}, 32'd0);
      check("mr_rdata", bus.rsp_rdata, 32'd0);
      check("mr_err", {31'd0, bus.rsp_err}, 32'd0);
      @(posedge clk);
      #1;
      check("mr_held_valid", {31'd0, bus.rsp_valid}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("mr_rel_pre_edge", {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("mr_rel_post_edge", {31'd0, bus.req_ready}, 32'd1);
      doTxn('{1'b0, 32'h30, 32'h0, 2'd0, 1'b0, 32'h0BADF00D, 1'b0}, 103);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
